// File: rtl/swc_pkg.sv
// ---------------------------------------------------------------------------
// swc_pkg
// Shared types and helpers for the swc_pack sample-width converter.
//   swc_state_e  : FILL (collecting lanes) / PEND (closed word waiting for
//                  the output register to free up)
//   MAX_RATIO    : widest supported packing ratio, sizes the keep helper
//   cnt_width()  : width of the lane fill counter / lvl status port
//   lane_idx()   : lane written by the beat that arrives at a given fill count
//   keep_mask()  : lane-valid mask for a word holding a given number of lanes
// ---------------------------------------------------------------------------
package swc_pkg;

    localparam int MAX_RATIO = 16;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PEND = 1'b1
    } swc_state_e;

    // The fill count runs 0..ratio inclusive, so it needs one extra code
    // beyond a plain lane index.
    function automatic int cnt_width(int ratio);
        return $clog2(ratio + 1);
    endfunction

    // LSB-first packing fills lanes upward from lane 0; MSB-first packing
    // fills downward from the top lane so the first word ends up highest.
    function automatic int lane_idx(int cnt, bit lsbFirst, int ratio);
        return lsbFirst ? cnt : (ratio - 1 - cnt);
    endfunction

    // Marks the lanes that hold data for a word of cnt lanes. MSB-first
    // packing fills from the top, so a partial word keeps the upper lanes.
    function automatic logic [MAX_RATIO-1:0] keep_mask(int cnt, bit lsbFirst, int ratio);
        logic [MAX_RATIO-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_RATIO; i++) begin
            if (i < ratio) begin
                if (lsbFirst) begin
                    if (i < cnt) begin
                        mask[i] = 1'b1;
                    end
                end else begin
                    if (i >= ratio - cnt) begin
                        mask[i] = 1'b1;
                    end
                end
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/swc_pack_if.sv
// ---------------------------------------------------------------------------
// swc_pack_if
// Handshake bundle for the swc_pack converter.
//   s_data/s_valid/s_last/s_ready : narrow input stream (DW bits per beat)
//   m_data/m_keep/m_last/m_valid/m_ready : wide output stream (RATIO lanes)
// Modports:
//   slave  : the converter's view (consumes s_*, produces m_*)
//   master : the surrounding logic's view (produces s_*, consumes m_*)
// ---------------------------------------------------------------------------
interface swc_pack_if #(
    parameter int DW    = 16,
    parameter int RATIO = 4
) ();

    logic [DW-1:0]       s_data;
    logic                s_valid;
    logic                s_last;
    logic                s_ready;

    logic [RATIO*DW-1:0] m_data;
    logic [RATIO-1:0]    m_keep;
    logic                m_last;
    logic                m_valid;
    logic                m_ready;

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_keep, m_last, m_valid
    );

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_keep, m_last, m_valid
    );

endinterface

// File: rtl/swc_out_reg.sv
// ---------------------------------------------------------------------------
// swc_out_reg
// Single-entry valid/ready holding register for a packed output word.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear_i      : drops the held word (valid and last)
//   load_i       : capture data_i/keep_i/last_i this edge
//   ready_i      : downstream accepts the held word
//   data_i/keep_i/last_i : word to capture
//   valid_o/data_o/keep_o/last_o : held word
// The caller only asserts load_i when the register is empty or draining, so
// a load always wins over the consume and the register never drops a word.
// ---------------------------------------------------------------------------
module swc_out_reg #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [KEEP_W-1:0] keep_i,
    input  logic              last_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [KEEP_W-1:0] keep_o,
    output logic              last_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [KEEP_W-1:0] keep_q, keep_d;
    logic              last_q, last_d;

    // Next-state for the holding register: clear drops the word, a load
    // replaces it, and otherwise a consumed word just loses its valid. The
    // payload is left untouched while stalled so it stays stable downstream.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (clear_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            keep_d  = keep_i;
            last_d  = last_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Register the holding stage; reset leaves an empty, all-zero word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;

endmodule

// File: rtl/swc_pack.sv
// ---------------------------------------------------------------------------
// swc_pack
// 1-to-RATIO sample-width converter: packs RATIO consecutive DW-bit beats
// into one RATIO*DW-bit word, with valid/ready on both sides and an
// end-of-packet marker that flushes a partial word with a lane-keep mask.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous discard of everything held, beats all else
//   bus          : swc_pack_if slave (s_* input stream, m_* output stream)
//   lvl          : lanes currently filled in the pack register (status)
// Parameters: DW word width, RATIO beats per word, LSB_FIRST lane order.
// ---------------------------------------------------------------------------
module swc_pack
    import swc_pkg::*;
#(
    parameter int DW        = 16,
    parameter int RATIO     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    swc_pack_if.slave                    bus,
    output logic [$clog2(RATIO+1)-1:0]   lvl
);

    localparam int CW  = cnt_width(RATIO);
    localparam int WW  = RATIO * DW;
    localparam bit LSB = (LSB_FIRST != 0);

    swc_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] packData_q, packData_d;
    logic          packLast_q, packLast_d;

    logic [WW-1:0]    beatData;
    logic [CW-1:0]    beatCnt;
    logic [CW-1:0]    keepCnt;
    int               laneSel;
    logic             outFree;
    logic             outLoad;
    logic [WW-1:0]    outData;
    logic [RATIO-1:0] outKeep;
    logic             outLast;
    logic             outValid;

    // The output register can take a new word when it is empty or when its
    // current word is being consumed this very cycle.
    assign outFree = !outValid || bus.m_ready;

    // Next-state and load control. In FILL each accepted beat drops into its
    // lane; the beat that fills the last lane or carries s_last closes the
    // word, which goes straight to the output register if that is free and
    // otherwise parks here in PEND (stalling input) until it is.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        packData_d = packData_q;
        packLast_d = packLast_q;
        outLoad    = 1'b0;
        outData    = packData_q;
        outLast    = packLast_q;
        keepCnt    = cnt_q;
        beatData   = packData_q;
        beatCnt    = cnt_q + CW'(1);
        laneSel    = 0;
        if (clear) begin
            state_d    = ST_FILL;
            cnt_d      = '0;
            packData_d = '0;
            packLast_d = 1'b0;
        end else begin
            case (state_q)
                ST_PEND: begin
                    if (outFree) begin
                        outLoad    = 1'b1;
                        state_d    = ST_FILL;
                        cnt_d      = '0;
                        packData_d = '0;
                        packLast_d = 1'b0;
                    end
                end
                ST_FILL: begin
                    if (bus.s_valid) begin
                        laneSel = lane_idx(int'(cnt_q), LSB, RATIO);
                        beatData[laneSel*DW +: DW] = bus.s_data;
                        if ((int'(cnt_q) == RATIO - 1) || bus.s_last) begin
                            if (outFree) begin
                                outLoad    = 1'b1;
                                outData    = beatData;
                                outLast    = bus.s_last;
                                keepCnt    = beatCnt;
                                cnt_d      = '0;
                                packData_d = '0;
                                packLast_d = 1'b0;
                            end else begin
                                state_d    = ST_PEND;
                                cnt_d      = beatCnt;
                                packData_d = beatData;
                                packLast_d = bus.s_last;
                            end
                        end else begin
                            cnt_d      = beatCnt;
                            packData_d = beatData;
                        end
                    end
                end
                default: begin
                    state_d = ST_FILL;
                end
            endcase
        end
    end

    // The mask helper is sized for the widest ratio; only the low RATIO
    // lanes exist here.
    assign outKeep = RATIO'(keep_mask(int'(keepCnt), LSB, RATIO));

    // Pack register and FSM state. Unused lanes are kept at zero so a flushed
    // partial word presents zeros in the lanes it never filled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_FILL;
            cnt_q      <= '0;
            packData_q <= '0;
            packLast_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            packData_q <= packData_d;
            packLast_q <= packLast_d;
        end
    end

    swc_out_reg #(
        .DATA_W (WW),
        .KEEP_W (RATIO)
    ) u_out_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (clear),
        .load_i  (outLoad),
        .ready_i (bus.m_ready),
        .data_i  (outData),
        .keep_i  (outKeep),
        .last_i  (outLast),
        .valid_o (outValid),
        .data_o  (bus.m_data),
        .keep_o  (bus.m_keep),
        .last_o  (bus.m_last)
    );

    // Input readiness depends only on registered state, so there is no
    // combinational path from s_valid or m_ready to s_ready.
    assign bus.s_ready = (state_q == ST_FILL);
    assign bus.m_valid = outValid;
    assign lvl         = cnt_q;

endmodule

// File: tb/tb_swc_pack.sv
// ---------------------------------------------------------------------------
// tb_swc_pack
// Drives two converters (LSB-first and MSB-first, DW=8, RATIO=4) with the
// same beats and ready pattern. Expected words are queued when stimulus is
// issued; a monitor pops and compares whenever a word is accepted.
// ---------------------------------------------------------------------------
module tb_swc_pack;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } expWord_t;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear   = 1'b0;
    logic [2:0] lvlA;
    logic [2:0] lvlB;

    int total = 0;
    int bad   = 0;
    bit randomReady = 1'b0;

    expWord_t expA[$];
    expWord_t expB[$];

    swc_pack_if #(.DW(8), .RATIO(4)) busA ();
    swc_pack_if #(.DW(8), .RATIO(4)) busB ();

    swc_pack #(.DW(8), .RATIO(4), .LSB_FIRST(1)) dutA (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (busA),
        .lvl     (lvlA)
    );

    swc_pack #(.DW(8), .RATIO(4), .LSB_FIRST(0)) dutB (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (busB),
        .lvl     (lvlB)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setInputs(input logic v, input logic [7:0] d, input logic l);
        busA.s_valid = v;
        busA.s_data  = d;
        busA.s_last  = l;
        busB.s_valid = v;
        busB.s_data  = d;
        busB.s_last  = l;
    endtask

    task automatic setReady(input logic r);
        busA.m_ready = r;
        busB.m_ready = r;
    endtask

    task automatic pushWord(input logic [31:0] dA, input logic [3:0] kA,
                            input logic [31:0] dB, input logic [3:0] kB, input logic l);
        expA.push_back('{data: dA, keep: kA, last: l});
        expB.push_back('{data: dB, keep: kB, last: l});
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (randomReady) setReady(1'($urandom_range(0, 1)));
        end
    endtask

    // Offer one beat until it is accepted; stalls reports waiting cycles.
    task automatic applyStimulus(input logic [7:0] d, input logic l, output int stalls);
        logic wasReady;
        bit   done;
        stalls = 0;
        done   = 1'b0;
        setInputs(1'b1, d, l);
        while (!done) begin
            @(negedge clk);
            wasReady = busA.s_ready;
            @(posedge clk);
            #1;
            if (randomReady) setReady(1'($urandom_range(0, 1)));
            if (wasReady) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 200) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL beat_timeout: data 0x%0h not accepted after %0d cycles, required acceptance", d, stalls);
                    done = 1'b1;
                end
            end
        end
        setInputs(1'b0, 8'h00, 1'b0);
    endtask

    task automatic waitDrain(input int limit);
        int cycles = 0;
        while ((expA.size() != 0 || expB.size() != 0) && cycles < limit) begin
            @(posedge clk);
            #1;
            if (randomReady) setReady(1'($urandom_range(0, 1)));
            cycles++;
        end
        total++;
        if (expA.size() != 0 || expB.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: %0d/%0d words still outstanding, required 0", expA.size(), expB.size());
        end
    endtask

    task automatic monitorLoop();
        expWord_t e;
        forever begin
            @(negedge clk);
            if (busA.m_valid && busA.m_ready) begin
                if (expA.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_A: got word 0x%0h, required no word", busA.m_data);
                end else begin
                    e = expA.pop_front();
                    checkOutput("A_data", busA.m_data, e.data);
                    checkOutput("A_keep", 32'(busA.m_keep), 32'(e.keep));
                    checkOutput("A_last", 32'(busA.m_last), 32'(e.last));
                end
            end
            if (busB.m_valid && busB.m_ready) begin
                if (expB.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_B: got word 0x%0h, required no word", busB.m_data);
                end else begin
                    e = expB.pop_front();
                    checkOutput("B_data", busB.m_data, e.data);
                    checkOutput("B_keep", 32'(busB.m_keep), 32'(e.keep));
                    checkOutput("B_last", 32'(busB.m_last), 32'(e.last));
                end
            end
        end
    endtask

    task automatic mainSequence();
        int st;
        int stallSum;
        int cntM;
        logic [7:0]  d;
        logic        l;
        logic [31:0] wA, wB;
        logic [3:0]  kA, kB;

        setInputs(1'b0, 8'h00, 1'b0);
        setReady(1'b0);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] reset values");
        checkOutput("rst_m_valid", 32'(busA.m_valid), 32'd0);
        checkOutput("rst_m_last", 32'(busA.m_last), 32'd0);
        checkOutput("rst_m_keep", 32'(busA.m_keep), 32'd0);
        checkOutput("rst_m_data", busA.m_data, 32'd0);
        checkOutput("rst_s_ready", 32'(busA.s_ready), 32'd1);
        checkOutput("rst_lvl", 32'(lvlA), 32'd0);
        checkOutput("rst_B_s_ready", 32'(busB.s_ready), 32'd1);

        $display("[TB] continuous stream");
        setReady(1'b1);
        stallSum = 0;
        pushWord(32'h44332211, 4'hF, 32'h11223344, 4'hF, 1'b0);
        applyStimulus(8'h11, 1'b0, st); stallSum += st;
        applyStimulus(8'h22, 1'b0, st); stallSum += st;
        applyStimulus(8'h33, 1'b0, st); stallSum += st;
        checkOutput("lat_before_valid", 32'(busA.m_valid), 32'd0);
        checkOutput("lvl_three", 32'(lvlA), 32'd3);
        applyStimulus(8'h44, 1'b0, st); stallSum += st;
        checkOutput("lat_valid", 32'(busA.m_valid), 32'd1);
        pushWord(32'h88776655, 4'hF, 32'h55667788, 4'hF, 1'b0);
        applyStimulus(8'h55, 1'b0, st); stallSum += st;
        applyStimulus(8'h66, 1'b0, st); stallSum += st;
        applyStimulus(8'h77, 1'b0, st); stallSum += st;
        applyStimulus(8'h88, 1'b0, st); stallSum += st;
        checkOutput("stream_stalls", 32'(stallSum), 32'd0);
        idleCycles(2);

        $display("[TB] flush");
        pushWord(32'h0000A2A1, 4'h3, 32'hA1A20000, 4'hC, 1'b1);
        applyStimulus(8'hA1, 1'b0, st);
        checkOutput("flush_lvl_one", 32'(lvlA), 32'd1);
        applyStimulus(8'hA2, 1'b1, st);
        checkOutput("flush_lvl_zero", 32'(lvlA), 32'd0);
        pushWord(32'h04030201, 4'hF, 32'h01020304, 4'hF, 1'b0);
        applyStimulus(8'h01, 1'b0, st);
        applyStimulus(8'h02, 1'b0, st);
        applyStimulus(8'h03, 1'b0, st);
        applyStimulus(8'h04, 1'b0, st);
        pushWord(32'h0000005A, 4'h1, 32'h5A000000, 4'h8, 1'b1);
        applyStimulus(8'h5A, 1'b1, st);
        idleCycles(2);

        $display("[TB] backpressure");
        setReady(1'b0);
        pushWord(32'h84838281, 4'hF, 32'h81828384, 4'hF, 1'b0);
        pushWord(32'h88878685, 4'hF, 32'h85868788, 4'hF, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'(8'h81 + i), 1'b0, st);
        end
        checkOutput("bp_s_ready_low", 32'(busA.s_ready), 32'd0);
        checkOutput("bp_lvl_full", 32'(lvlA), 32'd4);
        checkOutput("bp_hold_data", busA.m_data, 32'h84838281);
        idleCycles(3);
        checkOutput("bp_hold_valid", 32'(busA.m_valid), 32'd1);
        checkOutput("bp_hold_data_later", busA.m_data, 32'h84838281);
        checkOutput("bp_hold_keep", 32'(busA.m_keep), 32'hF);
        checkOutput("bp_hold_B_data", busB.m_data, 32'h81828384);
        checkOutput("bp_still_stalled", 32'(busA.s_ready), 32'd0);
        setReady(1'b1);
        idleCycles(3);
        checkOutput("bp_s_ready_back", 32'(busA.s_ready), 32'd1);
        checkOutput("bp_drained_valid", 32'(busA.m_valid), 32'd0);
        checkOutput("bp_drained_lvl", 32'(lvlA), 32'd0);

        $display("[TB] clear");
        applyStimulus(8'hC1, 1'b0, st);
        applyStimulus(8'hC2, 1'b0, st);
        applyStimulus(8'hC3, 1'b0, st);
        checkOutput("clr_lvl_before", 32'(lvlA), 32'd3);
        clear = 1'b1;
        setInputs(1'b1, 8'hEE, 1'b0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        setInputs(1'b0, 8'h00, 1'b0);
        checkOutput("clr_lvl", 32'(lvlA), 32'd0);
        checkOutput("clr_m_valid", 32'(busA.m_valid), 32'd0);
        pushWord(32'hD4D3D2D1, 4'hF, 32'hD1D2D3D4, 4'hF, 1'b0);
        applyStimulus(8'hD1, 1'b0, st);
        applyStimulus(8'hD2, 1'b0, st);
        applyStimulus(8'hD3, 1'b0, st);
        applyStimulus(8'hD4, 1'b0, st);
        idleCycles(2);
        setReady(1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'(8'hE1 + i), 1'b0, st);
        end
        checkOutput("clr_out_loaded", 32'(busA.m_valid), 32'd1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        checkOutput("clr_out_dropped", 32'(busA.m_valid), 32'd0);
        checkOutput("clr_out_last", 32'(busA.m_last), 32'd0);
        setReady(1'b1);
        idleCycles(2);

        $display("[TB] reset mid-word and mid-stall");
        setReady(1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'(8'h61 + i), 1'b0, st);
        end
        checkOutput("mid_valid", 32'(busA.m_valid), 32'd1);
        checkOutput("mid_lvl", 32'(lvlA), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_m_valid", 32'(busA.m_valid), 32'd0);
        checkOutput("arst_m_data", busA.m_data, 32'd0);
        checkOutput("arst_m_keep", 32'(busA.m_keep), 32'd0);
        checkOutput("arst_m_last", 32'(busA.m_last), 32'd0);
        checkOutput("arst_s_ready", 32'(busA.s_ready), 32'd1);
        checkOutput("arst_lvl", 32'(lvlA), 32'd0);
        checkOutput("arst_B_lvl", 32'(lvlB), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idleCycles(1);

        $display("[TB] random ready scoreboard");
        randomReady = 1'b1;
        cntM = 0;
        wA = '0; wB = '0; kA = '0; kB = '0;
        for (int i = 0; i < 24; i++) begin
            d = 8'(48 + i);
            l = (i == 5) || (i == 6) || (i == 13) || (i == 23);
            wA = wA | (32'(d) << (8 * cntM));
            wB = wB | (32'(d) << (8 * (3 - cntM)));
            kA = kA | (4'b0001 << cntM);
            kB = kB | (4'b1000 >> cntM);
            cntM++;
            if (cntM == 4 || l) begin
                pushWord(wA, kA, wB, kB, l);
                cntM = 0;
                wA = '0; wB = '0; kA = '0; kB = '0;
            end
            applyStimulus(d, l, st);
            if ($urandom_range(0, 3) == 0) idleCycles(1);
        end
        waitDrain(400);
        randomReady = 1'b0;
        setReady(1'b1);
        idleCycles(2);
    endtask

    initial begin
        fork
            monitorLoop();
            begin
                mainSequence();
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        join
    end

endmodule
